// File: rtl/uart_tx_word_arbiter.sv
//------------------------------------------------------------------------------
// Module  : uart_tx_word_arbiter
// Brief   : Round-robin word arbiter serialising two word requesters MSB-first
//           onto a single uart_tx byte stream. Optional tag byte per word when
//           UART_ARB_HEADER_EN is defined.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_word_arbiter #(
    parameter int         WORD_BYTES = 4,
    parameter logic [7:0] HDR0       = 8'hA0,
    parameter logic [7:0] HDR1       = 8'hA1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0_valid,
    input  logic [8*WORD_BYTES-1:0] req0_data,
    output logic                    req0_ready,
    input  logic                    req1_valid,
    input  logic [8*WORD_BYTES-1:0] req1_data,
    output logic                    req1_ready,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    input  logic                    tx_ready,
    output logic                    busy,
    output logic                    owner
);

    localparam int c_WIDTH = 8 * WORD_BYTES;
    localparam int c_CW    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_SEND = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_next_state;
    logic [c_WIDTH-1:0] r_shift;
    logic [c_CW-1:0]    r_count;
    logic               r_owner;
    logic               r_last_grant;
    logic               w_grant;
    logic               w_accept;
    logic               w_tx_fire;
    logic               w_last_byte;
`ifdef UART_ARB_HEADER_EN
    logic               r_hdr_pending;
`endif

    // Contention goes to whoever did not win last time
    always_comb begin
        w_grant = ~r_last_grant;
        if (req0_valid && !req1_valid) begin
            w_grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            w_grant = 1'b1;
        end
    end

    assign w_accept  = (r_state == c_IDLE) && (req0_valid || req1_valid);
    assign w_tx_fire = (r_state == c_SEND) && tx_ready;
`ifdef UART_ARB_HEADER_EN
    assign w_last_byte = w_tx_fire && !r_hdr_pending && (r_count == '0);
`else
    assign w_last_byte = w_tx_fire && (r_count == '0);
`endif

    assign req0_ready = w_accept && !w_grant;
    assign req1_ready = w_accept &&  w_grant;
    assign tx_valid   = (r_state == c_SEND);
    assign busy       = (r_state == c_SEND);
    assign owner      = r_owner;
`ifdef UART_ARB_HEADER_EN
    assign tx_data = r_hdr_pending ? (r_owner ? HDR1 : HDR0) : r_shift[c_WIDTH-1 -: 8];
`else
    assign tx_data = r_shift[c_WIDTH-1 -: 8];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_accept)    w_next_state = c_SEND;
            c_SEND:  if (w_last_byte) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift      <= '0;
            r_count      <= '0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
`ifdef UART_ARB_HEADER_EN
            r_hdr_pending <= 1'b0;
`endif
        end else if (w_accept) begin
            r_shift      <= w_grant ? req1_data : req0_data;
            r_count      <= c_CW'(WORD_BYTES - 1);
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
`ifdef UART_ARB_HEADER_EN
            r_hdr_pending <= 1'b1;
`endif
        end else if (w_tx_fire) begin
`ifdef UART_ARB_HEADER_EN
            if (r_hdr_pending) begin
                r_hdr_pending <= 1'b0;
            end else begin
                r_shift <= {r_shift[c_WIDTH-9:0], 8'h00};
                if (r_count != '0) r_count <= r_count - c_CW'(1);
            end
`else
            r_shift <= {r_shift[c_WIDTH-9:0], 8'h00};
            if (r_count != '0) r_count <= r_count - c_CW'(1);
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_word_arbiter.sv
// Bench for uart_tx_word_arbiter: queue-based reference model checked every cycle
// plus literal byte/grant/timing expectations for the directed scenarios.
`default_nettype none

module tb_uart_tx_word_arbiter;

`ifdef UART_ARB_HEADER_EN
    localparam int HB = 1;
`else
    localparam int HB = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        busy, owner;

    uart_tx_word_arbiter #(.WORD_BYTES(4), .HDR0(8'hA0), .HDR1(8'hA1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc   = 0;
    bit started = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, n_cyc);
        end
    endtask

    // Reference model: a byte queue per word, refilled on each grant
    logic [7:0] m_q[$];
    bit         m_send  = 1'b0;
    bit         m_last  = 1'b1;
    bit         m_owner = 1'b0;

    function automatic bit pick(input bit v0, input bit v1, input bit last);
        if (v0 && !v1) return 1'b0;
        if (v1 && !v0) return 1'b1;
        return !last;
    endfunction

    always @(posedge clk) begin
        n_cyc++;
        if (rst) begin
            m_send = 1'b0; m_q.delete(); m_last = 1'b1; m_owner = 1'b0;
        end else if (m_send) begin
            if (tx_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_send = 1'b0;
            end
        end else if (req0_valid || req1_valid) begin
            bit g;
            logic [31:0] w;
            g = pick(req0_valid, req1_valid, m_last);
            w = g ? req1_data : req0_data;
            if (HB == 1) m_q.push_back(g ? 8'hA1 : 8'hA0);
            for (int i = 3; i >= 0; i--) m_q.push_back(w[8*i +: 8]);
            m_owner = g; m_last = g; m_send = 1'b1;
        end
        started = 1'b1;
    end

    // Observation logs used by the literal checks
    logic [7:0] got[$];
    int         got_cyc[$];
    int         grants[$];
    int         acc_cyc[$];

    always @(negedge clk) begin
        if (started) begin
            bit g, e0, e1;
            g  = pick(req0_valid, req1_valid, m_last);
            e0 = !m_send && req0_valid && !g;
            e1 = !m_send && req1_valid &&  g;
            chk("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
            chk("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
            chk("tx_valid",   {31'd0, tx_valid},   {31'd0, m_send});
            chk("busy",       {31'd0, busy},       {31'd0, m_send});
            chk("owner",      {31'd0, owner},      {31'd0, m_owner});
            if (m_send) chk("tx_data", {24'd0, tx_data}, {24'd0, m_q[0]});
            if (!rst && tx_valid && tx_ready) begin
                got.push_back(tx_data); got_cyc.push_back(n_cyc);
            end
            if (!rst && req0_ready) begin grants.push_back(0); acc_cyc.push_back(n_cyc); end
            if (!rst && req1_ready) begin grants.push_back(1); acc_cyc.push_back(n_cyc); end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || tx_valid) && k < 100) begin tick(1); k++; end
        if (k >= 100) chk("idle_timeout", 32'd1, 32'd0);
        tick(1);
    endtask

    task automatic clear_logs();
        got.delete(); got_cyc.delete(); grants.delete(); acc_cyc.delete();
    endtask

    task automatic expect_word(input string nm, input int base, input logic [7:0] hdr,
                               input logic [31:0] w);
        if (got.size() < base + HB + 4) begin
            chk({nm, "_len"}, got.size(), base + HB + 4);
            return;
        end
        if (HB == 1) chk({nm, "_hdr"}, {24'd0, got[base]}, {24'd0, hdr});
        for (int i = 0; i < 4; i++)
            chk(nm, {24'd0, got[base + HB + i]}, {24'd0, w[8*(3-i) +: 8]});
    endtask

    initial begin
        tick(3);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_owner",    {31'd0, owner},    32'd0);
        rst = 1'b0;
        tick(1);

        // single word, full throughput
        clear_logs();
        tx_ready = 1'b1; req0_valid = 1'b1; req0_data = 32'ha14e28c5;
        tick(1);
        req0_valid = 1'b0;
        wait_idle();
        expect_word("t1_bytes", 0, 8'hA0, 32'ha14e28c5);
        chk("t1_grants", grants.size(), 1);
        if (got_cyc.size() >= 4 + HB && acc_cyc.size() >= 1) begin
            chk("t1_first_lat", got_cyc[0] - acc_cyc[0], 1);
            chk("t1_span", got_cyc[3 + HB] - got_cyc[0], 3 + HB);
        end

        // both requesters continuously valid from reset
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = 32'h11223344; req1_data = 32'h55667788;
        tick(2);
        clear_logs();
        rst = 1'b0;
        tick(20);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();
        if (grants.size() >= 4) begin
            chk("t2_g0", grants[0], 0); chk("t2_g1", grants[1], 1);
            chk("t2_g2", grants[2], 0); chk("t2_g3", grants[3], 1);
        end else chk("t2_grant_cnt", grants.size(), 4);
        expect_word("t2_w0", 0,          8'hA0, 32'h11223344);
        expect_word("t2_w1", 4 + HB,     8'hA1, 32'h55667788);
        expect_word("t2_w2", 2*(4 + HB), 8'hA0, 32'h11223344);

        // back-pressure mid-word
        clear_logs();
        req0_valid = 1'b1; req0_data = 32'hdeadbeef;
        tick(1);
        req0_valid = 1'b0;
        tick(2);
        tx_ready = 1'b0;
        tick(5);
        chk("t3_hold", {24'd0, tx_data}, (HB == 1) ? 32'hAD : 32'hBE);
        chk("t3_hold_valid", {31'd0, tx_valid}, 32'd1);
        tick(5);
        tx_ready = 1'b1;
        wait_idle();
        chk("t3_count", got.size(), 4 + HB);
        expect_word("t3_bytes", 0, 8'hA0, 32'hdeadbeef);

        // reset after two bytes, then resend
        clear_logs();
        req0_valid = 1'b1; req0_data = 32'ha0a1a2a3;
        tick(1);
        req0_valid = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
        chk("t4_abort_valid", {31'd0, tx_valid}, 32'd0);
        rst = 1'b0;
        req0_valid = 1'b1;
        tick(1);
        req0_valid = 1'b0;
        wait_idle();
        chk("t4_count", got.size(), 2 + 4 + HB);
        expect_word("t4_restart", 2, 8'hA0, 32'ha0a1a2a3);

        // requester 1 alone
        clear_logs();
        req1_valid = 1'b1; req1_data = 32'h01020304;
        tick(1);
        req1_valid = 1'b0;
        chk("t5_owner", {31'd0, owner}, 32'd1);
        wait_idle();
        expect_word("t5_bytes", 0, 8'hA1, 32'h01020304);

        // back-to-back words from one requester, data changed while sending
        clear_logs();
        req1_valid = 1'b1; req1_data = 32'h0badf00d;
        tick(1);
        req1_data = 32'hcafef00d;
        tick(11);
        req1_valid = 1'b0;
        wait_idle();
        expect_word("t6_w0", 0,      8'hA1, 32'h0badf00d);
        expect_word("t6_w1", 4 + HB, 8'hA1, 32'hcafef00d);
        if (got_cyc.size() >= 5 + HB)
            chk("t6_gap", got_cyc[4 + HB] - got_cyc[3 + HB], 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
